mips_cpu_bus_master: RTL and testbench
======================================

MIPS_CPU_BUS_MASTER -- requirements
Module: mips_cpu_bus_master

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, Avalon data width in bits (legal: 32, 64).
REQ-002 SHALL provide parameter TIMEOUT, default 255, max consecutive waitrequest cycles before abort (0 = never abort).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-004 SHALL have ports, in this order:
- clk  input  1  clock
- reset  input  1  async active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_signed  input  1  sign-extend load result
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data
- rsp_err  output  1  misaligned, illegal size or timeout
- busy  output  1  state is not IDLE
- mem_address  output  32  address aligned to DATA_W/8 bytes
- memread  output  1  Avalon read
- memwrite  output  1  Avalon write
- waitrequest  input  1  Avalon stall
- memwritedata  output  DATA_W  lane-shifted store data
- byteenable  output  DATA_W/8  active byte lanes
- memreaddata  input  DATA_W  Avalon read data, valid in any cycle with waitrequest low

Function
REQ-005 SHALL implement a three-state FSM: IDLE, BUS, DONE.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-007 SHALL register req_addr, req_size, req_signed, req_write and req_wdata on accept; core inputs are ignored outside IDLE.
REQ-008 SHALL, on accepting a legal aligned request, go IDLE->BUS.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0.
REQ-009 SHALL, on accepting a misaligned request or size 3, go IDLE->DONE with rsp_err=1 and generate no bus cycle.
REQ-010 SHALL, in BUS, drive memread=!write or memwrite=write, with mem_address, byteenable and memwritedata held stable while waitrequest=1.
REQ-011 SHALL never assert memread and memwrite together, and shall hold both at 0 outside BUS.
REQ-012 SHALL compute the lane as L = addr[log2(DATA_W/8)-1:0] and drive mem_address = addr with those bits cleared.
REQ-013 SHALL drive byteenable as 1<<L for byte, 3<<L for half, and 15<<L for word.
REQ-014 SHALL drive memwritedata = wdata<<(8*L), using only the low 8 or 16 bits of wdata for byte or half.
REQ-015 SHALL go BUS->DONE on the first cycle with waitrequest=0, capturing memreaddata in that cycle for reads.
REQ-016 SHALL drive rsp_rdata, for reads, as bytes starting at lane L, sized per req_size, and sign-extended if req_signed, otherwise zero-extended.
- For writes, rsp_rdata SHALL be 0.
REQ-017 SHALL count consecutive waitrequest=1 cycles in BUS when TIMEOUT>0.
- When the count reaches TIMEOUT, the FSM SHALL go BUS->DONE with rsp_err=1, deassert memread/memwrite, and drive rsp_rdata=0.
REQ-018 SHALL assert rsp_valid for exactly the one cycle spent in DONE, then go DONE->IDLE.
- rsp_rdata and rsp_err SHALL be valid only while rsp_valid=1.
REQ-019 SHALL give an aligned zero-wait transfer the timing: accept at edge N, bus cycle N..N+1, rsp_valid in cycle N+1..N+2, req_ready again from edge N+2.
REQ-020 SHALL, when waitrequest drops in the same cycle the timeout count would expire, complete the transfer normally with no error.
REQ-021 SHALL drive busy = (state != IDLE).

Reset
REQ-022 SHALL, while reset=0 and asynchronously, force state=IDLE, memread=0, memwrite=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, byteenable=0 and a timeout count of 0.
- req_ready SHALL be 0 while reset is asserted and 1 from the first clock after release.
REQ-023 SHALL, on reset asserted mid-BUS, abandon the transfer immediately and produce no rsp_valid for it.

Verification
REQ-024 SHALL pass this scenario with DATA_W=32: lw at 0x100, waitrequest=0, memreaddata=0xDEADBEEF -> byteenable=4'hF, mem_address=0x100, rsp_valid one cycle later, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-025 SHALL pass this scenario: lb signed at 0x103, memreaddata=0x80FFFFFF -> byteenable=4'h8, rsp_rdata=0xFFFFFF80.
- Repeating it as lbu SHALL give rsp_rdata=0x00000080.
REQ-026 SHALL pass this scenario: sh at 0x202, wdata=0x1234ABCD -> mem_address=0x200, byteenable=4'hC, memwritedata[31:16]=0xABCD, and all outputs held stable over 3 waitrequest cycles.
REQ-027 SHALL pass this scenario: lw at 0x101 -> no memread pulse, rsp_valid with rsp_err=1 on the cycle after accept.
REQ-028 SHALL pass this scenario with TIMEOUT=4: waitrequest stuck at 1 -> memread high for exactly 4 cycles, then rsp_err=1.
- The same scenario with reset pulsed low during BUS SHALL drop memread immediately and produce no rsp_valid.
REQ-029 SHALL pass this scenario with DATA_W=64: lhu at 0x10E, memreaddata=0xBEEF_0000_0000_0000 -> mem_address=0x108, byteenable=8'hC0, rsp_rdata=0x0000BEEF.

Source files
------------

// File: rtl/mips_cpu_bus_master.sv
// Bus master that turns MIPS core load/store requests into Avalon-MM transfers.
// Handles lane steering, load extension, alignment errors and a waitrequest timeout.
module mips_cpu_bus_master #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [31:0]         mem_address,
  output logic                memread,
  output logic                memwrite,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   memwritedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   memreaddata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return (a[0] == 1'b0);
      2'd2:    return (a == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_be(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    logic [NB-1:0] base;
    case (size)
      2'd0:    base = NB'(4'h1);
      2'd1:    base = NB'(4'h3);
      2'd2:    base = NB'(4'hF);
      default: base = '0;
    endcase
    return base << lane;
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] size,
                                                   input logic [LANE_W-1:0] lane,
                                                   input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      2'd0:    w = {24'h000000, wdata[7:0]};
      2'd1:    w = {16'h0000, wdata[15:0]};
      default: w = wdata;
    endcase
    return DATA_W'(w) << {lane, 3'b000};
  endfunction

  // Shift the addressed bytes down to bit 0, then zero- or sign-extend them.
  function automatic logic [31:0] load_extract(input logic [DATA_W-1:0] data,
                                               input logic [1:0] size,
                                               input logic sgn,
                                               input logic [LANE_W-1:0] lane);
    logic [DATA_W-1:0] sh;
    sh = data >> {lane, 3'b000};
    case (size)
      2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               in_bus;
  logic [LANE_W-1:0]  lane;

  assign accept = req_valid & ready_q;
  assign in_bus = (state_q == BUS);
  assign lane   = addr_q[LANE_W-1:0];

  // Next-state, request capture, response formation and waitrequest timeout.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = 32'h0000_0000;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          if (is_aligned(req_size, req_addr[1:0])) begin
            state_d = BUS;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // A dropped waitrequest wins over a timeout expiring in the same cycle.
        if (!waitrequest) begin
          state_d = DONE;
          cnt_d   = '0;
          if (write_q) begin
            rdata_d = 32'h0000_0000;
          end else begin
            rdata_d = load_extract(memreaddata, size_q, signed_q, lane);
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = DONE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and request registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0000_0000;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready    = ready_q;
  assign busy         = (state_q != IDLE);
  assign rsp_valid    = (state_q == DONE);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign memread      = in_bus & ~write_q;
  assign memwrite     = in_bus & write_q;
  assign mem_address  = {addr_q[31:LANE_W], {LANE_W{1'b0}}};
  assign byteenable   = in_bus ? lane_be(size_q, lane) : '0;
  assign memwritedata = (in_bus & write_q) ? lane_wdata(size_q, lane, wdata_q) : '0;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Scoreboard bench: a 32-bit master with TIMEOUT=4 and a 64-bit master share request inputs.
module tb_mips_cpu_bus_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_write, req_signed, waitrequest;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a, busy_a, memread_a, memwrite_a;
  logic [31:0] rsp_rdata_a, mem_address_a, memwritedata_a, memreaddata_a;
  logic [3:0]  byteenable_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b, busy_b, memread_b, memwrite_b;
  logic [31:0] rsp_rdata_b, mem_address_b;
  logic [63:0] memwritedata_b, memreaddata_b;
  logic [7:0]  byteenable_b;

  mips_cpu_bus_master #(.DATA_W(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a),
    .mem_address(mem_address_a), .memread(memread_a), .memwrite(memwrite_a),
    .waitrequest(waitrequest), .memwritedata(memwritedata_a),
    .byteenable(byteenable_a), .memreaddata(memreaddata_a)
  );

  mips_cpu_bus_master #(.DATA_W(64)) u_dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b),
    .mem_address(mem_address_b), .memread(memread_b), .memwrite(memwrite_b),
    .waitrequest(waitrequest), .memwritedata(memwritedata_b),
    .byteenable(byteenable_b), .memreaddata(memreaddata_b)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   bus_cnt_a = 0;
  rsp_t rq_a[$], rq_b[$];
  bus_t bq_a[$], bq_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input bit w64, input logic [31:0] rdata, input logic err, input int lat);
    rsp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat;
    if (w64) rq_b.push_back(e); else rq_a.push_back(e);
  endtask

  task automatic push_bus(input bit w64, input logic wr, input logic [31:0] addr,
                          input logic [7:0] be, input logic [63:0] wdata);
    bus_t b;
    b.wr = wr; b.addr = addr; b.be = be; b.wdata = wdata;
    if (w64) bq_b.push_back(b); else bq_a.push_back(b);
  endtask

  // Monitor for the 32-bit master: responses and bus activity.
  always @(negedge clk) begin : mon_a
    rsp_t e;
    bus_t b;
    if (reset) begin
      if (rsp_valid_a) begin
        if (rq_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_rsp_unexpected: got rsp_valid=1 expected none");
        end else begin
          e = rq_a.pop_front();
          chk("a_rsp_rdata", 64'(rsp_rdata_a), 64'(e.rdata));
          chk("a_rsp_err", 64'(rsp_err_a), 64'(e.err));
          chk("a_rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
        end
      end
      if (memread_a || memwrite_a) begin
        bus_cnt_a++;
        if (bq_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_bus_unexpected: got memread=%b memwrite=%b expected idle", memread_a, memwrite_a);
        end else begin
          b = bq_a[0];
          chk("a_bus_addr", 64'(mem_address_a), 64'(b.addr));
          chk("a_bus_be", 64'(byteenable_a), 64'(b.be));
          chk("a_bus_rw", {62'd0, memread_a, memwrite_a}, {62'd0, ~b.wr, b.wr});
          if (b.wr) chk("a_bus_wdata", 64'(memwritedata_a), b.wdata);
          if (!waitrequest) void'(bq_a.pop_front());
        end
      end
    end
  end

  // Monitor for the 64-bit master.
  always @(negedge clk) begin : mon_b
    rsp_t e;
    bus_t b;
    if (reset) begin
      if (rsp_valid_b) begin
        if (rq_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_rsp_unexpected: got rsp_valid=1 expected none");
        end else begin
          e = rq_b.pop_front();
          chk("b_rsp_rdata", 64'(rsp_rdata_b), 64'(e.rdata));
          chk("b_rsp_err", 64'(rsp_err_b), 64'(e.err));
          chk("b_rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
        end
      end
      if (memread_b || memwrite_b) begin
        if (bq_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_bus_unexpected: got memread=%b memwrite=%b expected idle", memread_b, memwrite_b);
        end else begin
          b = bq_b[0];
          chk("b_bus_addr", 64'(mem_address_b), 64'(b.addr));
          chk("b_bus_be", 64'(byteenable_b), 64'(b.be));
          chk("b_bus_rw", {62'd0, memread_b, memwrite_b}, {62'd0, ~b.wr, b.wr});
          if (b.wr) chk("b_bus_wdata", memwritedata_b, b.wdata);
          if (!waitrequest) void'(bq_b.pop_front());
        end
      end
    end
  end

  // Present one request and keep waitrequest high for nwait cycles (or forever if stuck).
  task automatic xfer(input bit w64, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd, input logic [63:0] mrd,
                      input int nwait, input bit stuck);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!(w64 ? req_ready_b : req_ready_a) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 20 cycles");
      return;
    end
    req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    memreaddata_a = mrd[31:0];
    memreaddata_b = mrd;
    waitrequest = stuck || (nwait > 0);
    if (w64) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    if (!stuck) begin
      for (int i = 1; i <= nwait; i++) begin
        @(posedge clk);
        #1;
        waitrequest = (i < nwait);
      end
    end
    guard = 0;
    while ((w64 ? busy_b : busy_a) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL busy_wait: got busy=1 expected 0 within 40 cycles");
    end
    waitrequest = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int snap;
    reset = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    waitrequest = 1'b0; memreaddata_a = 32'h0; memreaddata_b = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_a), 64'd0);
    chk("rst_memread", 64'(memread_a), 64'd0);
    chk("rst_memwrite", 64'(memwrite_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_a), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_a), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata_a), 64'd0);
    chk("rst_byteenable", 64'(byteenable_a), 64'd0);
    chk("rst_byteenable64", 64'(byteenable_b), 64'd0);
    reset = 1'b1;
    #1 chk("rel_req_ready_low", 64'(req_ready_a), 64'd0);
    @(negedge clk);
    chk("rel_req_ready_high", 64'(req_ready_a), 64'd1);

    // lw 0x100, zero wait
    push_bus(0, 1'b0, 32'h100, 8'hF, 64'h0);
    push_rsp(0, 32'hDEADBEEF, 1'b0, 1);
    xfer(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 64'hDEADBEEF, 0, 0);
    // lb / lbu at 0x103
    push_bus(0, 1'b0, 32'h100, 8'h8, 64'h0);
    push_rsp(0, 32'hFFFFFF80, 1'b0, 1);
    xfer(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 64'h80FFFFFF, 0, 0);
    push_bus(0, 1'b0, 32'h100, 8'h8, 64'h0);
    push_rsp(0, 32'h00000080, 1'b0, 1);
    xfer(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 64'h80FFFFFF, 0, 0);
    // sh 0x202 with 3 wait cycles; monitor re-checks the bus every stalled cycle
    push_bus(0, 1'b1, 32'h200, 8'hC, 64'hABCD0000);
    push_rsp(0, 32'h0, 1'b0, 4);
    xfer(0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 64'hFFFFFFFF, 3, 0);
    // misaligned word, illegal size, misaligned half
    push_rsp(0, 32'h0, 1'b1, 0);
    xfer(0, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 64'h12345678, 0, 0);
    push_rsp(0, 32'h0, 1'b1, 0);
    xfer(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 64'h12345678, 0, 0);
    push_rsp(0, 32'h0, 1'b1, 0);
    xfer(0, 1'b1, 2'd1, 1'b0, 32'h201, 32'h5555, 64'h0, 0, 0);
    // lh signed at 0x102
    push_bus(0, 1'b0, 32'h100, 8'hC, 64'h0);
    push_rsp(0, 32'hFFFF8001, 1'b0, 1);
    xfer(0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 64'h80011234, 0, 0);
    // sb 0x101 uses only the low byte
    push_bus(0, 1'b1, 32'h100, 8'h2, 64'h00005A00);
    push_rsp(0, 32'h0, 1'b0, 1);
    xfer(0, 1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF5A, 64'h0, 0, 0);
    // sw 0x10C, one wait
    push_bus(0, 1'b1, 32'h10C, 8'hF, 64'hCAFEF00D);
    push_rsp(0, 32'h0, 1'b0, 2);
    xfer(0, 1'b1, 2'd2, 1'b0, 32'h10C, 32'hCAFEF00D, 64'h0, 1, 0);
    // waitrequest stuck: exactly 4 memread cycles then error
    push_bus(0, 1'b0, 32'h300, 8'hF, 64'h0);
    push_rsp(0, 32'h0, 1'b1, 4);
    snap = bus_cnt_a;
    xfer(0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 64'h99999999, 0, 1);
    chk("timeout_memread_cycles", 64'(bus_cnt_a - snap), 64'd4);
    bq_a.delete();
    // waitrequest drops in the cycle the count would expire
    push_bus(0, 1'b0, 32'h304, 8'hF, 64'h0);
    push_rsp(0, 32'h11223344, 1'b0, 4);
    xfer(0, 1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 64'h11223344, 3, 0);

    // reset pulsed mid-BUS: memread drops at once and no response follows
    push_bus(0, 1'b0, 32'h400, 8'hF, 64'h0);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h400;
    waitrequest = 1'b1; req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midbus_memread_before", 64'(memread_a), 64'd1);
    reset = 1'b0;
    #1;
    chk("midbus_memread_after", 64'(memread_a), 64'd0);
    chk("midbus_busy_after", 64'(busy_a), 64'd0);
    chk("midbus_req_ready", 64'(req_ready_a), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    bq_a.delete();
    @(negedge clk);
    chk("midbus_ready_again", 64'(req_ready_a), 64'd1);
    // lhu at 0x106 after the reset
    push_bus(0, 1'b0, 32'h104, 8'hC, 64'h0);
    push_rsp(0, 32'h0000F00D, 1'b0, 1);
    xfer(0, 1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 64'hF00D1234, 0, 0);

    // 64-bit data path
    push_bus(1, 1'b0, 32'h108, 8'hC0, 64'h0);
    push_rsp(1, 32'h0000BEEF, 1'b0, 1);
    xfer(1, 1'b0, 2'd1, 1'b0, 32'h10E, 32'h0, 64'hBEEF000000000000, 0, 0);
    push_bus(1, 1'b0, 32'h108, 8'hF0, 64'h0);
    push_rsp(1, 32'h89ABCDEF, 1'b0, 1);
    xfer(1, 1'b0, 2'd2, 1'b0, 32'h10C, 32'h0, 64'h89ABCDEF01234567, 0, 0);
    push_bus(1, 1'b1, 32'h108, 8'h20, 64'h0000770000000000);
    push_rsp(1, 32'h0, 1'b0, 1);
    xfer(1, 1'b1, 2'd0, 1'b0, 32'h10D, 32'hAAAAAA77, 64'h0, 0, 0);
    push_bus(1, 1'b0, 32'h108, 8'h80, 64'h0);
    push_rsp(1, 32'hFFFFFFBE, 1'b0, 1);
    xfer(1, 1'b0, 2'd0, 1'b1, 32'h10F, 32'h0, 64'hBEEF000000000000, 0, 0);

    repeat (4) @(negedge clk);
    chk("a_rsp_queue_drained", 64'(rq_a.size()), 64'd0);
    chk("a_bus_queue_drained", 64'(bq_a.size()), 64'd0);
    chk("b_rsp_queue_drained", 64'(rq_b.size()), 64'd0);
    chk("b_bus_queue_drained", 64'(bq_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
